// File: rtl/hbm_fetch_pkg.sv
// Shared types and helpers for the HBM fetch engine: FSM states, beat size,
// and rounding of byte lengths up to whole beats.
package hbm_fetch_pkg;
  localparam int BEAT_BYTES = 64;

  typedef enum logic [1:0] {IDLE, SEND_RD_CMD, WAIT_DATA, DONE} state_e;

  function automatic logic [31:0] round_len(input logic [31:0] len);
    return (len + 32'(BEAT_BYTES - 1)) & ~32'(BEAT_BYTES - 1);
  endfunction
endpackage

// File: rtl/hbm_fetch_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data shows the head entry
// whenever empty is low. Reset flushes the pointers and the count.
module hbm_fetch_fifo #(
  parameter int DEPTH = 512,
  parameter int W     = 512,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_ok, rd_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/hbm_fetch_data.sv
// HBM fetch engine: splits a byte range into DMA read bursts, credit-limited
// so read data always fits the receive FIFO. Define HBM_FETCH_STAT_EN to build
// the rd_cycles launch-to-done counter; otherwise rd_cycles is tied to 0.
module hbm_fetch_data
  import hbm_fetch_pkg::*;
#(
  parameter int MAX_BURST_BYTES = 4096,
  parameter int FIFO_DEPTH      = 512
) (
  input  logic         hbm_clk,
  input  logic         hbm_rst,
  output logic         m_axis_dma_read_cmd_valid,
  input  logic         m_axis_dma_read_cmd_ready,
  output logic [63:0]  m_axis_dma_read_cmd_address,
  output logic [31:0]  m_axis_dma_read_cmd_length,
  input  logic [511:0] s_axis_dma_read_data_data,
  input  logic [63:0]  s_axis_dma_read_data_keep,
  input  logic         s_axis_dma_read_data_last,
  input  logic         s_axis_dma_read_data_valid,
  output logic         s_axis_dma_read_data_ready,
  input  logic         start,
  input  logic [63:0]  addr_x,
  input  logic [31:0]  data_length,
  output logic [511:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done,
  output logic [31:0]  rd_cycles
);
  localparam int          FCW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] MAX_LEN = 32'(MAX_BURST_BYTES);
  localparam logic [39:0] CAP     = 40'(FIFO_DEPTH) * 40'(BEAT_BYTES);

  state_e      state_q, state_d;
  logic        start_d0_q, start_d0_d, start_d1_q, start_d1_d;
  logic        in_rdy_q, in_rdy_d;
  logic [63:0] cur_addr_q, cur_addr_d;
  logic [31:0] remaining_q, remaining_d, total_q, total_d;
  logic [31:0] outstanding_q, outstanding_d, rx_bytes_q, rx_bytes_d;
  logic [31:0] cmd_len, rlen;
  logic [FCW-1:0] fifo_count;
  logic        fifo_full, fifo_empty, fifo_empty_n;
  logic        launch, credit_ok, cmd_hs, beat_acc, beat_wr;
  logic        unused_in;

  assign unused_in = ^{s_axis_dma_read_data_keep, s_axis_dma_read_data_last};

  assign launch    = start_d1_q && (state_q == IDLE);
  assign rlen      = round_len(data_length);
  assign cmd_len   = (remaining_q < MAX_LEN) ? remaining_q : MAX_LEN;
  // Count bytes already buffered plus bytes still in flight against capacity.
  assign credit_ok = (40'(fifo_count) * 40'(BEAT_BYTES) + 40'(outstanding_q) + 40'(cmd_len)) <= CAP;

  assign m_axis_dma_read_cmd_valid   = (state_q == SEND_RD_CMD) && credit_ok;
  assign m_axis_dma_read_cmd_address = cur_addr_q;
  assign m_axis_dma_read_cmd_length  = cmd_len;
  assign cmd_hs = m_axis_dma_read_cmd_valid && m_axis_dma_read_cmd_ready;

  assign s_axis_dma_read_data_ready = in_rdy_q && !fifo_full;
  assign beat_acc = s_axis_dma_read_data_valid && s_axis_dma_read_data_ready;
  assign beat_wr  = beat_acc && (state_q == SEND_RD_CMD || state_q == WAIT_DATA);

  assign out_valid = fifo_empty_n;
  assign fifo_empty_n = !fifo_empty;
  assign busy      = (state_q != IDLE) || launch;
  assign done      = (state_q == DONE);

  hbm_fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(512)) u_fifo (
    .clk     (hbm_clk),
    .rst     (hbm_rst),
    .wr_en   (beat_wr),
    .wr_data (s_axis_dma_read_data_data),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    start_d0_d    = start;
    start_d1_d    = start_d0_q;
    in_rdy_d      = 1'b1;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    total_d       = total_q;
    rx_bytes_d    = beat_wr ? rx_bytes_q + 32'(BEAT_BYTES) : rx_bytes_q;
    outstanding_d = outstanding_q + (cmd_hs ? cmd_len : 32'd0)
                  - (beat_wr ? 32'(BEAT_BYTES) : 32'd0);
    if (cmd_hs) begin
      cur_addr_d  = cur_addr_q + 64'(cmd_len);
      remaining_d = remaining_q - cmd_len;
    end
    case (state_q)
      IDLE: if (launch) begin
        cur_addr_d    = addr_x;
        remaining_d   = rlen;
        total_d       = rlen;
        rx_bytes_d    = '0;
        outstanding_d = '0;
        state_d       = (rlen == '0) ? DONE : SEND_RD_CMD;
      end
      SEND_RD_CMD: if (cmd_hs && remaining_q == cmd_len) state_d = WAIT_DATA;
      WAIT_DATA:   if (rx_bytes_q >= total_q) state_d = DONE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge hbm_clk) begin
    if (hbm_rst) begin
      state_q       <= IDLE;
      start_d0_q    <= 1'b0;
      start_d1_q    <= 1'b0;
      in_rdy_q      <= 1'b0;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      total_q       <= '0;
      outstanding_q <= '0;
      rx_bytes_q    <= '0;
    end else begin
      state_q       <= state_d;
      start_d0_q    <= start_d0_d;
      start_d1_q    <= start_d1_d;
      in_rdy_q      <= in_rdy_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      total_q       <= total_d;
      outstanding_q <= outstanding_d;
      rx_bytes_q    <= rx_bytes_d;
    end
  end

`ifdef HBM_FETCH_STAT_EN
  logic [31:0] rd_cycles_q, rd_cycles_d;

  // The launch cycle itself counts, so the value matches the busy-high cycles.
  always_comb begin
    rd_cycles_d = rd_cycles_q;
    if (launch)                rd_cycles_d = 32'd1;
    else if (state_q != IDLE)  rd_cycles_d = rd_cycles_q + 32'd1;
  end

  always_ff @(posedge hbm_clk) begin
    if (hbm_rst) rd_cycles_q <= '0;
    else         rd_cycles_q <= rd_cycles_d;
  end

  assign rd_cycles = rd_cycles_q;
`else
  assign rd_cycles = '0;
`endif
endmodule

// File: tb/tb_hbm_fetch_data.sv
// Directed bench for hbm_fetch_data: a DMA slave model answers read commands
// with address-tagged beats, and a consumer logs the output stream.
module tb_hbm_fetch_data;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid, cmd_ready;
  logic [63:0]  cmd_addr;
  logic [31:0]  cmd_len;
  logic [511:0] d_data;
  logic [63:0]  d_keep = '1;
  logic         d_last = 1'b0;
  logic         d_valid, d_ready;
  logic         start = 1'b0;
  logic [63:0]  addr_x = '0;
  logic [31:0]  data_length = '0;
  logic [511:0] out_data;
  logic         out_valid, out_ready;
  logic         busy, done;
  logic [31:0]  rd_cycles;

  int checks = 0;
  int errors = 0;

  logic cmd_rdy_en  = 1'b1;
  logic out_rdy_en  = 1'b1;
  int   cmd_delay   = 0;
  int   beat_budget = -1;
  int   busy_cnt = 0, done_cnt = 0, stall_cnt = 0, beats_sent = 0;
  logic [63:0]  cmd_addr_log[$];
  logic [31:0]  cmd_len_log[$];
  logic [63:0]  beat_q[$];
  logic [511:0] out_log[$];

  always #5 clk = ~clk;

  hbm_fetch_data #(.MAX_BURST_BYTES(4096), .FIFO_DEPTH(64)) dut (
    .hbm_clk                     (clk),
    .hbm_rst                     (rst),
    .m_axis_dma_read_cmd_valid   (cmd_valid),
    .m_axis_dma_read_cmd_ready   (cmd_ready),
    .m_axis_dma_read_cmd_address (cmd_addr),
    .m_axis_dma_read_cmd_length  (cmd_len),
    .s_axis_dma_read_data_data   (d_data),
    .s_axis_dma_read_data_keep   (d_keep),
    .s_axis_dma_read_data_last   (d_last),
    .s_axis_dma_read_data_valid  (d_valid),
    .s_axis_dma_read_data_ready  (d_ready),
    .start                       (start),
    .addr_x                      (addr_x),
    .data_length                 (data_length),
    .out_data                    (out_data),
    .out_valid                   (out_valid),
    .out_ready                   (out_ready),
    .busy                        (busy),
    .done                        (done),
    .rd_cycles                   (rd_cycles)
  );

  function automatic logic [511:0] pat(input logic [63:0] a);
    return {8{a}};
  endfunction

  function automatic logic [63:0] log_addr(input int i);
    return (i < cmd_addr_log.size()) ? cmd_addr_log[i] : '1;
  endfunction

  function automatic logic [31:0] log_len(input int i);
    return (i < cmd_len_log.size()) ? cmd_len_log[i] : '1;
  endfunction

  function automatic logic [511:0] log_out(input int i);
    return (i < out_log.size()) ? out_log[i] : '1;
  endfunction

  // Slave/consumer model: drives at the falling edge, handshakes resolve at the next rising edge.
  initial begin
    logic [63:0] dummy;
    int unsigned nb;
    cmd_ready = 1'b0; d_valid = 1'b0; d_data = '0; out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (beat_q.size() > 0 && beat_budget != 0) begin
        d_valid = 1'b1;
        d_data  = pat(beat_q[0]);
      end else begin
        d_valid = 1'b0;
      end
      if (d_valid && d_ready) begin
        dummy = beat_q.pop_front();
        beats_sent++;
        if (beat_budget > 0) beat_budget--;
      end
      if (d_valid && !d_ready && !rst) stall_cnt++;
      if (cmd_delay > 0) begin
        cmd_ready = 1'b0;
        if (cmd_valid) cmd_delay--;
      end else begin
        cmd_ready = cmd_rdy_en;
      end
      if (cmd_valid && cmd_ready) begin
        cmd_addr_log.push_back(cmd_addr);
        cmd_len_log.push_back(cmd_len);
        nb = cmd_len >> 6;
        for (int i = 0; i < int'(nb); i++) beat_q.push_back(cmd_addr + 64'(i * 64));
      end
      out_ready = out_rdy_en;
      if (out_valid && out_ready) out_log.push_back(out_data);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    cmd_addr_log.delete(); cmd_len_log.delete(); out_log.delete();
    busy_cnt = 0; done_cnt = 0; stall_cnt = 0; beats_sent = 0;
  endtask

  task automatic launch(input logic [63:0] a, input logic [31:0] len);
    addr_x = a; data_length = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt < 1 && k < budget) begin tick(); k++; end
    chk(tag, 64'(done_cnt), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
    chk({tag, "_in_ready"},  64'(d_ready),   64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_done"},      64'(done),      64'd0);
    chk({tag, "_rd_cycles"}, 64'(rd_cycles), 64'd0);
  endtask

  task automatic chk_rd(input string tag, input int exp_cycles);
`ifdef HBM_FETCH_STAT_EN
    chk(tag, 64'(rd_cycles), 64'(exp_cycles));
`else
    chk(tag, 64'(rd_cycles), 64'(exp_cycles * 0));
`endif
  endtask

  initial begin
    int k;
    tick(3);
    chk_reset_outputs("rst");
    rst = 1'b0;
    tick(2);

    // 256 bytes -> one command, four beats in order
    clear_logs();
    launch(64'h1000, 32'd256);
    wait_done("t1_done", 200);
    tick(10);
    chk("t1_ncmd", 64'(cmd_addr_log.size()), 64'd1);
    chk("t1_addr", log_addr(0), 64'h1000);
    chk("t1_len",  64'(log_len(0)), 64'd256);
    chk("t1_nout", 64'(out_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) chkd("t1_beat", log_out(i), pat(64'h1000 + 64'(i * 64)));
    chk("t1_done_once", 64'(done_cnt), 64'd1);
    chk_rd("t1_rd_cycles", busy_cnt);

    // 10000 bytes -> 4096 + 4096 + 1856; a start pulse while busy is ignored
    clear_logs();
    launch(64'h20000, 32'd10000);
    k = 0;
    while (cmd_addr_log.size() < 1 && k < 100) begin tick(); k++; end
    start = 1'b1; tick(); start = 1'b0;
    wait_done("t2_done", 3000);
    tick(10);
    chk("t2_idle_after", 64'(busy), 64'd0);
    chk("t2_ncmd", 64'(cmd_addr_log.size()), 64'd3);
    chk("t2_addr0", log_addr(0), 64'h20000);
    chk("t2_len0",  64'(log_len(0)), 64'd4096);
    chk("t2_addr1", log_addr(1), 64'h21000);
    chk("t2_len1",  64'(log_len(1)), 64'd4096);
    chk("t2_addr2", log_addr(2), 64'h22000);
    chk("t2_len2",  64'(log_len(2)), 64'd1856);
    chk("t2_nout", 64'(out_log.size()), 64'd157);
    for (int i = 0; i < 157; i++) chkd("t2_beat", log_out(i), pat(64'h20000 + 64'(i * 64)));

    // consumer stalled: credit allows only one 4096-byte burst into a 64-beat FIFO
    clear_logs();
    out_rdy_en = 1'b0;
    launch(64'h40000, 32'd16384);
    tick(300);
    chk("t3_ncmd_stalled", 64'(cmd_addr_log.size()), 64'd1);
    chk("t3_len0", 64'(log_len(0)), 64'd4096);
    chk("t3_out_valid", 64'(out_valid), 64'd1);
    chk("t3_busy", 64'(busy), 64'd1);
    chk("t3_stall_held", 64'(stall_cnt), 64'd0);
    out_rdy_en = 1'b1;
    wait_done("t3_done", 3000);
    tick(10);
    chk("t3_ncmd", 64'(cmd_addr_log.size()), 64'd4);
    chk("t3_nout", 64'(out_log.size()), 64'd256);
    for (int i = 0; i < 256; i++) chkd("t3_beat", log_out(i), pat(64'h40000 + 64'(i * 64)));
    chk("t3_stall", 64'(stall_cnt), 64'd0);

    // zero length -> no command, busy for the launch and DONE cycles
    clear_logs();
    launch(64'h5000, 32'd0);
    wait_done("t4_done", 50);
    tick(5);
    chk("t4_ncmd", 64'(cmd_addr_log.size()), 64'd0);
    chk("t4_busy_cycles", 64'(busy_cnt), 64'd2);
    chk("t4_done_once", 64'(done_cnt), 64'd1);
    chk_rd("t4_rd_cycles", 2);

    // reset after 2 of 8 beats; late beats discarded; then a clean 128-byte fetch
    clear_logs();
    beat_budget = 2;
    launch(64'h80000, 32'd512);
    k = 0;
    while (beats_sent < 2 && k < 200) begin tick(); k++; end
    tick(3);
    chk("t5_beats_before_rst", 64'(beats_sent), 64'd2);
    rst = 1'b1;
    tick(2);
    chk_reset_outputs("t5_rst");
    rst = 1'b0;
    beat_budget = -1;
    k = 0;
    while (beat_q.size() > 0 && k < 100) begin tick(); k++; end
    tick(3);
    chk("t5_stale_drained", 64'(beat_q.size()), 64'd0);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_ncmd_abort", 64'(cmd_addr_log.size()), 64'd1);
    chk("t5_no_done", 64'(done_cnt), 64'd0);
    clear_logs();
    launch(64'h90000, 32'd128);
    wait_done("t5_done", 200);
    tick(5);
    chk("t5_ncmd", 64'(cmd_addr_log.size()), 64'd1);
    chk("t5_addr", log_addr(0), 64'h90000);
    chk("t5_len",  64'(log_len(0)), 64'd128);
    chk("t5_nout", 64'(out_log.size()), 64'd2);
    for (int i = 0; i < 2; i++) chkd("t5_beat", log_out(i), pat(64'h90000 + 64'(i * 64)));

    // 64 bytes with command ready held off 5 cycles -> 10 busy cycles
    clear_logs();
    cmd_delay = 5;
    launch(64'hA000, 32'd64);
    wait_done("t6_done", 200);
    tick(5);
    chk("t6_ncmd", 64'(cmd_addr_log.size()), 64'd1);
    chk("t6_nout", 64'(out_log.size()), 64'd1);
    chkd("t6_beat", log_out(0), pat(64'hA000));
    chk("t6_busy_cycles", 64'(busy_cnt), 64'd10);
    chk_rd("t6_rd_cycles", 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hbm_fetch_data.md
HBM_FETCH_DATA -- requirements
Module: hbm_fetch_data

Interface
REQ-001 SHALL have parameter MAX_BURST_BYTES, default 4096, meaning the largest byte length of one DMA read command (multiple of 64).
REQ-002 SHALL have parameter FIFO_DEPTH, default 512, meaning the receive FIFO depth in 512-bit beats (power of two).
REQ-003 SHALL have port hbm_clk  input  1  the single clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port hbm_rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have port m_axis_dma_read_cmd  axis_mem_cmd.master  -  read command: valid, ready, address[63:0], length[31:0].
REQ-006 SHALL have port s_axis_dma_read_data  axi_stream.slave  -  read data: data[511:0], keep[63:0], last, valid, ready.
REQ-007 SHALL have port start  input  1  launch request, level-sampled.
REQ-008 SHALL have port addr_x  input  64  byte start address, sampled at launch.
REQ-009 SHALL have port data_length  input  32  byte count, sampled at launch.
REQ-010 SHALL have port out_data  output  512  fetched beat.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts beat.
REQ-013 SHALL have port busy  output  1  high while not IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse at completion.
REQ-015 SHALL have port rd_cycles  output  32  launch-to-done cycle count (see Configuration).

Function
REQ-016 SHALL register start through two flops (start_d0, start_d1); launch occurs when start_d1=1 in IDLE; start in any other state SHALL be ignored.
REQ-017 SHALL at launch latch addr_x into cur_addr and ceil(data_length/64)*64 into remaining_cmd and total_bytes.
REQ-018 SHALL use states IDLE, SEND_RD_CMD, WAIT_DATA, DONE; IDLE->SEND_RD_CMD on launch, or IDLE->DONE if rounded length is 0.
REQ-019 SHALL in SEND_RD_CMD assert cmd valid only when credit allows; length = min(remaining_cmd, MAX_BURST_BYTES), address = cur_addr.
REQ-020 SHALL hold address/length stable while valid and not ready; on valid&ready add length to cur_addr and outstanding_bytes, subtract from remaining_cmd.
REQ-021 SHALL transition SEND_RD_CMD->WAIT_DATA on the handshake that makes remaining_cmd 0; otherwise stay.
REQ-022 Credit: cmd valid SHALL require (fifo_count*64 + outstanding_bytes + next length) <= FIFO_DEPTH*64, so read data never overflows the FIFO.
REQ-023 SHALL drive s_axis ready = ~fifo_full; each accepted beat in SEND_RD_CMD/WAIT_DATA SHALL be written to the FIFO, decrement outstanding_bytes by 64, increment rx_bytes by 64.
REQ-024 Simultaneous cmd handshake and data beat SHALL update outstanding_bytes by +length-64 in the same cycle.
REQ-025 Beats arriving in IDLE or DONE SHALL be accepted and discarded.
REQ-026 SHALL transition WAIT_DATA->DONE when rx_bytes >= total_bytes; DONE->IDLE unconditionally next cycle, with done=1 for that single DONE cycle.
REQ-027 out_valid SHALL equal ~fifo_empty (FWFT); a FIFO read occurs on out_valid&out_ready; output draining is independent of state.
REQ-028 keep and last on input SHALL be ignored; all counters 32-bit, wrap not required (data_length < 2^32-64).

Reset
REQ-029 While hbm_rst=1: state IDLE, cmd valid 0, s_axis ready 0, out_valid 0, busy 0, done 0, rd_cycles 0, all counters 0, FIFO flushed, start_d0/d1 0.
REQ-030 Reset mid-operation SHALL abort the transfer without issuing further commands; stale beats after reset fall under REQ-025.

Configuration
REQ-031 With HBM_FETCH_STAT_EN defined, rd_cycles SHALL clear at launch, increment each cycle while busy, and hold its value after done until the next launch.
REQ-032 Without HBM_FETCH_STAT_EN, rd_cycles SHALL be constant 0 and the counter SHALL not be built.

Structure
REQ-033 Package hbm_fetch_pkg SHALL hold the state enum, BEAT_BYTES=64 and the length-rounding function.
REQ-034 SHALL instantiate one sub-module hbm_fetch_fifo: synchronous FWFT FIFO, 512-bit, FIFO_DEPTH entries, exposing count, full, empty.

Verification
REQ-035 start high, addr_x=0x1000, data_length=256, cmd ready=1 -> one cmd {0x1000,256}; 4 beats in -> 4 beats out in order; done pulse once.
REQ-036 data_length=10000, MAX_BURST_BYTES=4096 -> cmds {A,4096},{A+4096,4096},{A+8192,1856}; done after 157 beats.
REQ-037 FIFO_DEPTH=64, out_ready=0, data_length=16384 -> exactly 1 cmd of 4096 issued; no second cmd until the consumer drains; no overflow.
REQ-038 data_length=0 -> no cmd; done one cycle after IDLE->DONE; busy 2 cycles.
REQ-039 hbm_rst asserted after 2 of 8 beats -> all outputs reset values; late beats discarded; new launch of 128 bytes completes correctly.
REQ-040 With HBM_FETCH_STAT_EN, cmd ready delayed 5 cycles on 64-byte read -> rd_cycles equals measured busy cycles; without macro -> 0.
